// File: rtl/ex_3_window_acc.sv
// Valid-qualified sample accumulator: moving-window sum (mode 0) or saturating
// running sum with sticky overflow (mode 1). Registered output, 1-cycle latency.
module ex_3_window_acc #(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 4,
    localparam int OUT_W  = DATA_W + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              mode,
    input  logic [DATA_W-1:0] x,
    input  logic              x_is_valid,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              full,
    output logic              ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [OUT_W:0] Y_MAX = {1'b0, {OUT_W{1'b1}}};

    logic [DEPTH-1:0][DATA_W-1:0] win_q;
    logic [PTR_W-1:0]             wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0]             count, count_n;
    logic                         mode_q;
    logic                         clear;
    logic [OUT_W-1:0]             y_n;
    logic                         y_valid_n, full_n, ovf_n;
    logic [OUT_W:0]               sat_sum;
    logic [OUT_W-1:0]             win_sum;

    // A mode switch is treated exactly like an explicit clear.
    assign clear   = clr | (mode != mode_q);
    assign sat_sum = {1'b0, y} + (OUT_W + 1)'(x);
    // Unfilled entries are zero, so this is exact even before the window fills.
    assign win_sum = y + OUT_W'(x) - OUT_W'(win_q[wr_ptr]);

    always_comb begin
        y_n       = y;
        y_valid_n = 1'b0;
        ovf_n     = ovf;
        wr_ptr_n  = wr_ptr;
        count_n   = count;
        if (clear) begin
            ovf_n    = 1'b0;
            y_n      = x_is_valid ? OUT_W'(x) : '0;
            wr_ptr_n = x_is_valid ? PTR_W'(1) : '0;
            count_n  = x_is_valid ? CNT_W'(1) : '0;
            y_valid_n = x_is_valid;
        end else if (x_is_valid) begin
            y_valid_n = 1'b1;
            if (!mode_q) begin
                y_n      = win_sum;
                wr_ptr_n = wr_ptr + PTR_W'(1);
                if (count != CNT_W'(DEPTH))
                    count_n = count + CNT_W'(1);
            end else if (sat_sum > Y_MAX) begin
                y_n   = Y_MAX[OUT_W-1:0];
                ovf_n = 1'b1;
            end else begin
                y_n = sat_sum[OUT_W-1:0];
            end
        end
        // mode_q takes the value of mode on this edge in every case.
        full_n = (count_n == CNT_W'(DEPTH)) && !mode;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            full    <= 1'b0;
            ovf     <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            mode_q  <= mode;
        end else begin
            y       <= y_n;
            y_valid <= y_valid_n;
            full    <= full_n;
            ovf     <= ovf_n;
            count   <= count_n;
            wr_ptr  <= wr_ptr_n;
            mode_q  <= mode;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst)
                win_q[i] <= '0;
            else if (clear)
                win_q[i] <= (i == 0 && x_is_valid) ? x : '0;
            else if (x_is_valid && !mode_q && wr_ptr == PTR_W'(i))
                win_q[i] <= x;
        end
    end
endmodule

// File: tb/tb_ex_3_window_acc.sv
// Bench for ex_3_window_acc: directed scenarios plus random traffic, checked
// against a queue-based window / saturating-sum reference model.
module tb_ex_3_window_acc;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int OUT_W  = DATA_W + $clog2(DEPTH);
    localparam int Y_MAX  = (1 << OUT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              mode = 1'b0;
    logic [DATA_W-1:0] x = '0;
    logic              x_is_valid = 1'b0;
    logic [OUT_W-1:0]  y;
    logic              y_valid, full, ovf;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int win[$];
    int m_y = 0;
    bit m_yv = 0, m_full = 0, m_ovf = 0, m_mode = 0;

    ex_3_window_acc #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .x(x),
        .x_is_valid(x_is_valid), .y(y), .y_valid(y_valid), .full(full), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic int win_total();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic model_edge();
        if (!rst) begin
            win.delete();
            m_y = 0; m_yv = 0; m_full = 0; m_ovf = 0; m_mode = mode;
        end else if (clr || mode != m_mode) begin
            m_mode = mode;
            win.delete();
            m_ovf = 0;
            m_yv  = x_is_valid;
            if (x_is_valid) win.push_back(int'(x));
            m_y    = x_is_valid ? int'(x) : 0;
            m_full = 0;
        end else if (x_is_valid) begin
            m_yv = 1;
            if (!m_mode) begin
                win.push_back(int'(x));
                if (win.size() > DEPTH) void'(win.pop_front());
                m_y    = win_total();
                m_full = (win.size() == DEPTH);
            end else begin
                if (m_y + int'(x) > Y_MAX) begin
                    m_y = Y_MAX; m_ovf = 1;
                end else begin
                    m_y = m_y + int'(x);
                end
                m_full = 0;
            end
        end else begin
            m_yv = 0;
        end
    endtask

    task automatic chk_model(input string tag);
        n_assert++;
        assert (y === OUT_W'(m_y)) else begin
            n_fail++; $error("FAIL %s y: got %0d expected %0d", tag, y, m_y);
        end
        n_assert++;
        assert (y_valid === m_yv) else begin
            n_fail++; $error("FAIL %s y_valid: got %b expected %b", tag, y_valid, m_yv);
        end
        n_assert++;
        assert (full === m_full) else begin
            n_fail++; $error("FAIL %s full: got %b expected %b", tag, full, m_full);
        end
        n_assert++;
        assert (ovf === m_ovf) else begin
            n_fail++; $error("FAIL %s ovf: got %b expected %b", tag, ovf, m_ovf);
        end
    endtask

    // Apply one edge of stimulus, then check DUT against the model.
    task automatic step(input bit r, input bit c, input bit m, input bit v,
                        input logic [DATA_W-1:0] xx, input string tag);
        rst = r; clr = c; mode = m; x_is_valid = v; x = xx;
        @(posedge clk);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    // Directed check against hand-derived constants.
    task automatic expect4(input string tag, input int ey, input bit ev,
                           input bit ef, input bit eo);
        n_assert++;
        assert (y === OUT_W'(ey) && y_valid === ev && full === ef && ovf === eo) else begin
            n_fail++;
            $error("FAIL %s: got y=%0d v=%b f=%b o=%b expected y=%0d v=%b f=%b o=%b",
                   tag, y, y_valid, full, ovf, ey, ev, ef, eo);
        end
    endtask

    initial begin
        int ys2[5]  = '{4, 12, 13, 15, 26};
        bit fs2[5]  = '{0, 0, 0, 1, 1};
        int xs2[5]  = '{4, 8, 1, 2, 15};
        int ys4[5]  = '{15, 30, 45, 60, 63};
        bit r, c, v;
        bit m;

        // 1. reset with valid data present
        step(0, 0, 0, 1, 4'hF, "rst1"); expect4("rst1", 0, 0, 0, 0);
        step(0, 0, 0, 1, 4'hF, "rst2"); expect4("rst2", 0, 0, 0, 0);

        // 2. window fill and first eviction
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 4'(xs2[i]), "win");
            expect4($sformatf("win%0d", i), ys2[i], 1, fs2[i], 0);
        end

        // 3. max samples, idle cycle in the middle
        step(1, 1, 0, 0, 4'h0, "clr3"); expect4("clr3", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 4'hF, "maxw");
            expect4($sformatf("maxw%0d", i), 15 * (i + 1), 1, i == 3, 0);
        end
        step(1, 0, 0, 0, 4'h0, "idle"); expect4("idle", 60, 0, 1, 0);
        step(1, 0, 0, 1, 4'hF, "maxw4"); expect4("maxw4", 60, 1, 1, 0);
        step(1, 0, 0, 1, 4'hF, "maxw5"); expect4("maxw5", 60, 1, 1, 0);

        // 4. saturating accumulate, then clear-with-load
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 1, 4'hF, "sat");
            expect4($sformatf("sat%0d", i), ys4[i], 1, 0, i == 4);
        end
        step(1, 0, 1, 0, 4'h0, "sathold"); expect4("sathold", 63, 0, 0, 1);
        step(1, 1, 1, 1, 4'h3, "clrld"); expect4("clrld", 3, 1, 0, 0);

        // 5. refill window to 26, then a mode change without valid clears it
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 4'(xs2[i]), "refill");
        expect4("refill", 26, 1, 1, 0);
        step(1, 0, 1, 0, 4'h0, "modechg"); expect4("modechg", 0, 0, 0, 0);

        // 6. mid-stream reset must zero the buffer
        step(1, 0, 0, 1, 4'h5, "pre6a"); expect4("pre6a", 5, 1, 0, 0);
        step(1, 0, 0, 1, 4'h7, "pre6b"); expect4("pre6b", 12, 1, 0, 0);
        step(0, 0, 0, 1, 4'h9, "midrst"); expect4("midrst", 0, 0, 0, 0);
        step(1, 0, 0, 1, 4'h2, "postrst"); expect4("postrst", 2, 1, 0, 0);

        // random traffic against the model
        m = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) != 0);
            c = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 24) == 0) m = ~m;
            v = ($urandom_range(0, 3) != 0);
            step(r, c, m, v, 4'($urandom_range(0, 15)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
